// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

    // Canonical RISC-V NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // S_RUN  : fetch responses are consumed
    // S_DROP : one in-flight response belongs to a squashed path and is discarded
    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_DROP = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry pc/instr holding register that catches a fetch response
// arriving while decode is stalled.
module if_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    // Occupancy flag: flush wins over load, load wins over drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Payload is captured only on load; its content is irrelevant while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= 32'h0;
            instr <= 32'h0;
        end else if (load && !flush) begin
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register. Handles memory wait states,
// load-use stalls (via the skid buffer) and EX-resolved redirects.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_RUN  | normal fetch; accepted responses go to IF/ID or the skid buffer
// S_DROP | redirect arrived mid-request; discard that response, then
//        | restart fetching at tgt
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  tgt;
    logic         req_en;
    logic         buf_valid;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_instr;

    logic         accept;
    logic         run_accept;
    logic [31:0]  redirect_tgt;
    logic         unused_redirect_lsbs;

    // Request is decoded from registers only, so no input reaches it combinationally.
    assign imem_req  = req_en & ~buf_valid;
    assign imem_addr = pc;

    assign accept     = imem_req & imem_rvalid;
    assign run_accept = accept & (state == S_RUN);

    // Targets are word-aligned; the low bits from EX are ignored.
    assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Requests are held off for one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_en <= 1'b0;
        end else begin
            req_en <= 1'b1;
        end
    end

    // Fetch PC and drop-state control. The outstanding address must not move
    // while a request is pending, so a mid-request redirect parks in tgt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            state <= S_RUN;
            tgt   <= 32'h0;
        end else if (redirect) begin
            if (state == S_RUN) begin
                if (accept || !imem_req) begin
                    pc <= redirect_tgt;
                end else begin
                    tgt   <= redirect_tgt;
                    state <= S_DROP;
                end
            end else begin
                tgt <= redirect_tgt;
            end
        end else if (state == S_DROP) begin
            if (accept) begin
                pc    <= tgt;
                state <= S_RUN;
            end
        end else if (accept) begin
            pc <= pc + 32'd4;
        end
    end

    if_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (stall & ~redirect & run_accept),
        .drain      (~stall & ~redirect & buf_valid),
        .flush      (redirect),
        .load_pc    (pc),
        .load_instr (imem_rdata),
        .valid      (buf_valid),
        .pc         (buf_pc),
        .instr      (buf_instr)
    );

    // IF/ID register: redirect flushes, stall holds, otherwise buffer first,
    // then a fresh response, else a bubble (id_pc keeps its last value).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_pc    <= 32'h0;
            id_instr <= NOP_INSTR;
        end else if (redirect) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (stall) begin
            id_valid <= id_valid;
        end else if (buf_valid) begin
            id_valid <= 1'b1;
            id_pc    <= buf_pc;
            id_instr <= buf_instr;
        end else if (run_accept) begin
            id_valid <= 1'b1;
            id_pc    <= pc;
            id_instr <= imem_rdata;
        end else begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: zero-wait streaming, wait states, stall into
// the skid buffer, redirect during a pending request, redirect+stall, and
// reset in the middle of a wait.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    int checks = 0;
    int errors = 0;

    // Memory model: word at address A reads as {A[31:2], 2'b11}.
    assign imem_rdata = {imem_addr[31:2], 2'b11};

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] p, input logic [31:0] ins);
        chk({tag, ".valid"}, {31'h0, id_valid}, {31'h0, v});
        chk({tag, ".pc"}, id_pc, p);
        chk({tag, ".instr"}, id_instr, ins);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req"}, {31'h0, imem_req}, 32'h0);
        chk({tag, ".addr"}, imem_addr, 32'h0);
        chk_id(tag, 1'b0, 32'h0, NOP);
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_rvalid = 1'b1;

        // ---- reset and zero-wait streaming ----
        tick();
        tick();
        chk_reset_outputs("rst0");
        rst_n = 1'b1;
        tick();
        chk("zw.req_e1", {31'h0, imem_req}, 32'h1);
        chk("zw.addr_e1", imem_addr, 32'h0);
        chk("zw.valid_e1", {31'h0, id_valid}, 32'h0);
        tick();
        chk_id("zw0", 1'b1, 32'h0, 32'h3);
        tick();
        chk_id("zw4", 1'b1, 32'h4, 32'h7);
        tick();
        chk_id("zw8", 1'b1, 32'h8, 32'hB);
        tick();
        chk_id("zw12", 1'b1, 32'hC, 32'hF);

        // ---- re-reset mid-stream, then two wait states on 0x8 ----
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst1");
        tick();
        rst_n = 1'b1;
        tick();
        chk("ws.addr0", imem_addr, 32'h0);
        tick();
        chk_id("ws.id0", 1'b1, 32'h0, 32'h3);
        tick();
        chk_id("ws.id4", 1'b1, 32'h4, 32'h7);
        imem_rvalid = 1'b0;
        chk("ws.addr8_a", imem_addr, 32'h8);
        tick();
        chk("ws.addr8_b", imem_addr, 32'h8);
        chk("ws.bubble1", {31'h0, id_valid}, 32'h0);
        chk("ws.bubble1_instr", id_instr, NOP);
        tick();
        chk("ws.addr8_c", imem_addr, 32'h8);
        chk("ws.bubble2", {31'h0, id_valid}, 32'h0);
        imem_rvalid = 1'b1;
        tick();
        chk_id("ws.id8", 1'b1, 32'h8, 32'hB);

        // ---- stall 3 cycles while 0xC response arrives ----
        stall = 1'b1;
        chk("st.addrC", imem_addr, 32'hC);
        tick();
        chk_id("st.hold1", 1'b1, 32'h8, 32'hB);
        chk("st.buf1", {31'h0, dut.buf_valid}, 32'h1);
        chk("st.req1", {31'h0, imem_req}, 32'h0);
        tick();
        chk_id("st.hold2", 1'b1, 32'h8, 32'hB);
        chk("st.req2", {31'h0, imem_req}, 32'h0);
        tick();
        chk_id("st.hold3", 1'b1, 32'h8, 32'hB);
        chk("st.buf3", {31'h0, dut.buf_valid}, 32'h1);
        stall = 1'b0;
        tick();
        chk_id("st.drainC", 1'b1, 32'hC, 32'hF);
        chk("st.buf_empty", {31'h0, dut.buf_valid}, 32'h0);
        chk("st.next_req", {31'h0, imem_req}, 32'h1);
        chk("st.next_addr", imem_addr, 32'h10);

        // ---- redirect to 0x103 while 0x10 is still waiting ----
        imem_rvalid = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        chk_id("rd.flush", 1'b0, 32'hC, NOP);
        chk("rd.addr_held1", imem_addr, 32'h10);
        chk("rd.req_held1", {31'h0, imem_req}, 32'h1);
        tick();
        chk("rd.addr_held2", imem_addr, 32'h10);
        chk("rd.valid2", {31'h0, id_valid}, 32'h0);
        imem_rvalid = 1'b1;
        tick();
        chk("rd.dropped", {31'h0, id_valid}, 32'h0);
        chk("rd.dropped_instr", id_instr, NOP);
        chk("rd.addr_tgt", imem_addr, 32'h100);
        tick();
        chk_id("rd.id100", 1'b1, 32'h100, 32'h103);

        // ---- redirect and stall together with a full buffer ----
        stall = 1'b1;
        tick();
        chk("rs.buf_full", {31'h0, dut.buf_valid}, 32'h1);
        chk_id("rs.hold", 1'b1, 32'h100, 32'h103);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        chk("rs.valid", {31'h0, id_valid}, 32'h0);
        chk("rs.instr", id_instr, NOP);
        chk("rs.buf_cleared", {31'h0, dut.buf_valid}, 32'h0);
        chk("rs.req", {31'h0, imem_req}, 32'h1);
        chk("rs.addr", imem_addr, 32'h200);
        tick();
        chk_id("rs.id200", 1'b1, 32'h200, 32'h203);

        // ---- reset asserted in the middle of a wait ----
        imem_rvalid = 1'b0;
        tick();
        chk("mw.addr", imem_addr, 32'h204);
        chk("mw.req", {31'h0, imem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mw.rst_now");
        tick();
        chk_reset_outputs("mw.rst_edge");
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        tick();
        chk("mw.restart_req", {31'h0, imem_req}, 32'h1);
        chk("mw.restart_addr", imem_addr, 32'h0);
        tick();
        chk_id("mw.id0", 1'b1, 32'h0, 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
